// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_DONE
   } arb_state_t;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/arb2_picker.sv
// Combinational two-way picker used by mem_port_arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (load/store wins ties).
module arb2_picker
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |req;
      grant_id    = PORT_IF;
      if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         grant_id = PORT_LS;
`else
         // On a tie, hand the memory to whichever port was not served last.
         grant_id = ~last_grant;
`endif
      end else if (req[1]) begin
         grant_id = PORT_LS;
      end
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port data memory between instruction fetch (port 0) and load/store (port 1).
// Build option: MEM_ARB_FIXED_PRIO_EN drops the round-robin pointer and favours port 1 on ties.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p0_req,
   input  logic             p0_we,
   input  logic [WIDTH-1:0] p0_addr,
   input  logic [WIDTH-1:0] p0_wdata,
   output logic             p0_ack,
   output logic [WIDTH-1:0] p0_rdata,
   input  logic             p1_req,
   input  logic             p1_we,
   input  logic [WIDTH-1:0] p1_addr,
   input  logic [WIDTH-1:0] p1_wdata,
   output logic             p1_ack,
   output logic [WIDTH-1:0] p1_rdata,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [WIDTH-1:0] Address,
   output logic [WIDTH-1:0] WD,
   input  logic [WIDTH-1:0] RD,
   output logic             busy
);

   arb_state_t       state_q, state_d;
   logic             grant_id_q, grant_id_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [WIDTH-1:0] address_q, address_d;
   logic [WIDTH-1:0] wd_q, wd_d;
   logic             p0_ack_q, p0_ack_d;
   logic             p1_ack_q, p1_ack_d;
   logic [WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic [WIDTH-1:0] p1_rdata_q, p1_rdata_d;

   logic             last_grant;
   logic             pick_valid;
   logic             pick_id;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign last_grant = PORT_LS;
`else
   logic last_grant_q, last_grant_d;
   assign last_grant = last_grant_q;
`endif

   arb2_picker u_picker (
      .req         ({p1_req, p0_req}),
      .last_grant  (last_grant),
      .grant_valid (pick_valid),
      .grant_id    (pick_id)
   );

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      address_d   = address_q;
      wd_d        = wd_q;
      p0_ack_d    = 1'b0;
      p1_ack_d    = 1'b0;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif

      unique case (state_q)
         ARB_IDLE: begin
            // The winner's request is latched straight into the memory-side registers.
            if (pick_valid) begin
               state_d    = ARB_ACCESS;
               grant_id_d = pick_id;
`ifndef MEM_ARB_FIXED_PRIO_EN
               last_grant_d = pick_id;
`endif
               if (pick_id == PORT_LS) begin
                  mem_read_d  = ~p1_we;
                  mem_write_d = p1_we;
                  address_d   = p1_addr;
                  wd_d        = p1_wdata;
               end else begin
                  mem_read_d  = ~p0_we;
                  mem_write_d = p0_we;
                  address_d   = p0_addr;
                  wd_d        = p0_wdata;
               end
            end
         end
         ARB_ACCESS: begin
            state_d = ARB_DONE;
            if (grant_id_q == PORT_LS) begin
               p1_ack_d = 1'b1;
               if (mem_read_q) p1_rdata_d = RD;
            end else begin
               p0_ack_d = 1'b1;
               if (mem_read_q) p0_rdata_d = RD;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         grant_id_q  <= PORT_IF;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         address_q   <= '0;
         wd_q        <= '0;
         p0_ack_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         address_q   <= address_d;
         wd_q        <= wd_d;
         p0_ack_q    <= p0_ack_d;
         p1_ack_q    <= p1_ack_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
      end
   end

`ifndef MEM_ARB_FIXED_PRIO_EN
   // Reset points at port 1 so instruction fetch wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= PORT_LS;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign MemRead  = mem_read_q;
   assign MemWrite = mem_write_q;
   assign Address  = address_q;
   assign WD       = wd_q;
   assign p0_ack   = p0_ack_q;
   assign p1_ack   = p1_ack_q;
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;
   assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected acks plus per-cycle invariants.
module tb_mem_port_arbiter;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             p0_req = 1'b0, p0_we = 1'b0;
   logic [WIDTH-1:0] p0_addr = '0, p0_wdata = '0;
   logic             p0_ack;
   logic [WIDTH-1:0] p0_rdata;
   logic             p1_req = 1'b0, p1_we = 1'b0;
   logic [WIDTH-1:0] p1_addr = '0, p1_wdata = '0;
   logic             p1_ack;
   logic [WIDTH-1:0] p1_rdata;
   logic             mem_read, mem_write, busy;
   logic [WIDTH-1:0] address, wd, rd;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_ack   (p0_ack),
      .p0_rdata (p0_rdata),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p1_ack   (p1_ack),
      .p1_rdata (p1_rdata),
      .MemRead  (mem_read),
      .MemWrite (mem_write),
      .Address  (address),
      .WD       (wd),
      .RD       (rd),
      .busy     (busy)
   );

   // Behavioural memory: combinational read, write on the closing edge of the access cycle.
   logic [WIDTH-1:0] mem_model [0:255];
   assign rd = mem_model[address[7:0]];
   always @(posedge clk) begin
      if (mem_write) mem_model[address[7:0]] <= wd;
   end

   typedef struct {
      logic             port;
      logic             we;
      logic [WIDTH-1:0] rdata;
   } exp_t;

   exp_t             sb_q[$];
   int               tests_run = 0;
   int               tests_failed = 0;
   int               ack_seen = 0;
   logic             prev_acc = 1'b0;
   logic             prev2_acc = 1'b0;
   logic [WIDTH-1:0] model_rdata0 = '0;
   logic [WIDTH-1:0] model_rdata1 = '0;

   // Advance one cycle, then check invariants and retire any ack against the scoreboard.
   task automatic tick();
      exp_t e;
      logic acc;
      @(posedge clk);
      @(negedge clk);
      acc = mem_read | mem_write;
      tests_run++;
      if ((mem_read & mem_write) !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mem_excl: MemRead=%b MemWrite=%b, required not both 1", mem_read, mem_write);
      end
      tests_run++;
      if ((p0_ack & p1_ack) !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ack_excl: p0_ack=%b p1_ack=%b, required not both 1", p0_ack, p1_ack);
      end
      if (p0_ack || p1_ack) begin
         ack_seen++;
         tests_run++;
         if (!(prev_acc && !prev2_acc && !acc)) begin
            tests_failed++;
            $display("[TB] FAIL ack_timing: access history %b%b now %b, required 010", prev2_acc, prev_acc, acc);
         end
         tests_run++;
         if (sb_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_ack: p0_ack=%b p1_ack=%b, required no ack", p0_ack, p1_ack);
         end else begin
            e = sb_q.pop_front();
            if (p1_ack !== e.port) begin
               tests_failed++;
               $display("[TB] FAIL grant_port: got port %b, expected port %b", p1_ack, e.port);
            end
            if (!e.we) begin
               if (e.port) model_rdata1 = e.rdata;
               else        model_rdata0 = e.rdata;
            end
         end
      end
      tests_run++;
      if (p0_rdata !== model_rdata0) begin
         tests_failed++;
         $display("[TB] FAIL p0_rdata: got %h, expected %h", p0_rdata, model_rdata0);
      end
      tests_run++;
      if (p1_rdata !== model_rdata1) begin
         tests_failed++;
         $display("[TB] FAIL p1_rdata: got %h, expected %h", p1_rdata, model_rdata1);
      end
      prev2_acc = prev_acc;
      prev_acc  = acc;
   endtask

   task automatic applyStimulus(input logic port, input logic we,
                                input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   task automatic push_exp(input logic port, input logic we, input logic [WIDTH-1:0] rdata);
      exp_t e;
      e.port = port; e.we = we; e.rdata = rdata;
      sb_q.push_back(e);
   endtask

   task automatic wait_acks(input int target);
      int n = 0;
      while (ack_seen < target && n < 40) begin
         tick();
         n++;
      end
      tests_run++;
      if (ack_seen < target) begin
         tests_failed++;
         $display("[TB] FAIL ack_timeout: got %0d acks, expected %0d", ack_seen, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({mem_read, mem_write, p0_ack, p1_ack, busy} !== 5'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {mem_read, mem_write, p0_ack, p1_ack, busy});
      end
      tests_run++;
      if ({address, wd} !== 64'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_bus: Address=%h WD=%h, expected 0", address, wd);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
      push_exp(1'b0, 1'b0, 32'hDEADBEEF);
      tests_run++;
      if ({mem_read, busy} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL rd_cycle1: MemRead,busy=%b, expected 00", {mem_read, busy});
      end
      tick();
      tests_run++;
      if ({mem_read, mem_write, busy, p0_ack} !== 4'b1010 || address !== 32'h10) begin
         tests_failed++;
         $display("[TB] FAIL rd_cycle2: ctrl=%b addr=%h, expected 1010 addr 00000010", {mem_read, mem_write, busy, p0_ack}, address);
      end
      tick();
      tests_run++;
      if ({mem_read, p0_ack, busy} !== 3'b011 || p0_rdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL rd_cycle3: ctrl=%b rdata=%h, expected 011 deadbeef", {mem_read, p0_ack, busy}, p0_rdata);
      end
      p0_req = 1'b0;
      tick();
      tests_run++;
      if ({mem_read, p0_ack, busy} !== 3'b000 || address !== 32'h10) begin
         tests_failed++;
         $display("[TB] FAIL rd_after: ctrl=%b addr=%h, expected 000 addr 00000010", {mem_read, p0_ack, busy}, address);
      end
   endtask

   task automatic test_write_then_read();
      int base = ack_seen;
      applyStimulus(1'b1, 1'b1, 32'h20, 32'h0000_00A5);
      push_exp(1'b1, 1'b1, 32'h0);
      tick();
      tests_run++;
      if ({mem_read, mem_write} !== 2'b01 || address !== 32'h20 || wd !== 32'hA5) begin
         tests_failed++;
         $display("[TB] FAIL wr_access: rw=%b addr=%h wd=%h, expected 01 00000020 000000a5", {mem_read, mem_write}, address, wd);
      end
      wait_acks(base + 1);
      p1_req = 1'b0;
      tests_run++;
      if (p0_rdata !== 32'hDEADBEEF || p1_rdata !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL wr_rdata_hold: p0=%h p1=%h, expected deadbeef 00000000", p0_rdata, p1_rdata);
      end
      tick();
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0);
      push_exp(1'b0, 1'b0, 32'hA5);
      wait_acks(base + 2);
      p0_req = 1'b0;
      tests_run++;
      if (p0_rdata !== 32'hA5) begin
         tests_failed++;
         $display("[TB] FAIL rd_after_wr: got %h, expected 000000a5", p0_rdata);
      end
      tick();
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
      push_exp(1'b1, 1'b0, 32'hA5);
      wait_acks(base + 3);
      p1_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int base = ack_seen;
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         push_exp(1'b1, 1'b0, 32'h3333_4444);
`else
         if (i % 2 == 0) push_exp(1'b0, 1'b0, 32'h1111_2222);
         else            push_exp(1'b1, 1'b0, 32'h3333_4444);
`endif
      end
      applyStimulus(1'b0, 1'b0, 32'h30, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h34, 32'h0);
      wait_acks(base + 4);
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
      tick();
      tests_run++;
      if (busy !== 1'b0 || sb_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_drain: busy=%b pending=%0d, expected 0 0", busy, sb_q.size());
      end
   endtask

   task automatic test_reset_mid_access();
      int base;
      applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
      tick();
      tests_run++;
      if (mem_read !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rst_pre_access: MemRead=%b, expected 1", mem_read);
      end
      rst = 1'b1;
      p0_req = 1'b0;
      model_rdata0 = '0;
      model_rdata1 = '0;
      tick();
      tests_run++;
      if ({mem_read, mem_write, p0_ack, p1_ack, busy} !== 5'b0 || address !== 32'h0 || wd !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid: ctrl=%b addr=%h wd=%h, expected 00000 0 0", {mem_read, mem_write, p0_ack, p1_ack, busy}, address, wd);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if ({p0_ack, busy} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL rst_no_ack: ack,busy=%b, expected 00", {p0_ack, busy});
      end
      // The pointer was at port 0 before reset; reset must point it back at port 1.
      base = ack_seen;
`ifdef MEM_ARB_FIXED_PRIO_EN
      push_exp(1'b1, 1'b0, 32'h3333_4444);
`else
      push_exp(1'b0, 1'b0, 32'h5555_6666);
`endif
      applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h34, 32'h0);
      wait_acks(base + 1);
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
      mem_model[8'h10] = 32'hDEADBEEF;
      mem_model[8'h30] = 32'h1111_2222;
      mem_model[8'h34] = 32'h3333_4444;
      mem_model[8'h40] = 32'h5555_6666;
      @(negedge clk);
      test_reset();
      test_single_read();
      test_write_then_read();
      test_back_to_back();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
